lcd_receive: RTL and testbench
==============================

// Module: lcd_receive
// PURPOSE
//  Read side of the HD44780 8-bit character-LCD interface. lcd_transmit only writes to the panel.
//  This block performs single read cycles (RW=1) on request:
//   - RS=0 returns busy flag + address counter.
//   - RS=1 returns a data byte from DDRAM/CGRAM.
//  It sits next to lcd_transmit. Top level muxes lcd_rs/lcd_en/lcd_rw and tri-states lcd_d while bus_req=1.
// PARAMETERS
//  T_AS   2   clk cycles RS/RW setup before EN rises (>=60ns at 12MHz)
//  T_PW   12  clk cycles EN held high (>=450ns min; 1us at 12MHz)
//  T_HOLD 2   clk cycles RS/RW held after EN falls
//  T_REC  24  clk cycles EN low before done (completes >=1us+ cycle time)
//  T_TO   255 busy-poll attempt limit (only used with LCD_BUSY_POLL_EN)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous active-low reset
//  start      in   1  1-cycle request; sampled only in IDLE
//  rs_sel     in   1  0=read BF/AC, 1=read data; captured with start
//  lcd_d_in   in   8  LCD data bus input (pad input path)
//  bus_req    out  1  high for whole transaction; top must release lcd_d, select this block's rs/rw/en
//  lcd_rs     out  1  register select to LCD
//  lcd_rw     out  1  1=read, high from SETUP through HOLD
//  lcd_en     out  1  enable strobe
//  rd_data    out  8  byte sampled during the last read; stable until next sample
//  busy_flag  out  1  rd_data[7] when last read was RS=0, else unchanged
//  addr       out  7  rd_data[6:0] when last read was RS=0, else unchanged
//  done_tick  out  1  1-cycle pulse when transaction complete
// BEHAVIOUR
//  Reset values: bus_req=0, lcd_rs=0, lcd_rw=0, lcd_en=0, rd_data=0, busy_flag=1 (pessimistic), addr=0, done_tick=0.
//  Reset is async assert, sync release. Reset mid-cycle drops lcd_en/lcd_rw the same instant and returns to IDLE; no done_tick.
//  FSM with a single 8-bit down-counter cnt:
//   - IDLE: outputs low.
//       - start=1: latch rs_sel, bus_req=1, lcd_rw=1, lcd_rs=rs_sel, cnt=T_AS-1 -> SETUP.
//   - SETUP: lcd_en=0; when cnt==0: lcd_en=1, cnt=T_PW-1 -> ENHI.
//   - ENHI: lcd_en=1; when cnt==0: capture lcd_d_in into rd_data (data valid >=tDDR).
//       - Same edge: lcd_en=0, cnt=T_HOLD-1 -> HOLD.
//   - HOLD: rs/rw held; when cnt==0: lcd_rw=0, bus_req=0, cnt=T_REC-1 -> RECOV.
//   - RECOV: when cnt==0: done_tick=1 for one cycle -> IDLE.
//  Capture: lcd_d_in sampled on the clk edge ending ENHI; goes through one sync register stage first.
//   - So the sampled value is lcd_d_in as of one cycle before EN falls.
//  Latency start->done_tick = 1+T_AS+T_PW+T_HOLD+T_REC cycles (41 with defaults). Back-to-back start on the done_tick cycle is accepted.
//  start outside IDLE is ignored (no queue). rs_sel only captured with an accepted start.
//  Zero parameter values are illegal; each state lasts >=1 cycle.
//  busy_flag/addr update on the same edge as rd_data, only when latched rs_sel=0.
// CONFIGURATION
//  LCD_BUSY_POLL_EN defined:
//   - Adds input poll_start and output poll_timeout.
//   - poll_start in IDLE runs repeated RS=0 reads, back-to-back, until the sampled bit7==0.
//       - Then one done_tick, poll_timeout=0.
//   - Or until T_TO reads, then done_tick with poll_timeout=1.
//   - poll_timeout clears on the next accepted start/poll_start.
//   - start and poll_start together: poll_start wins.
//  Not defined: single reads only. poll_start/poll_timeout ports absent; behaviour otherwise identical.
// TESTING
//  1 rst low mid-ENHI (cycle 8):
//     - lcd_en=0, lcd_rw=0, bus_req=0 immediately.
//     - After release: IDLE, no done_tick, busy_flag=1.
//  2 start, rs_sel=0; model drives 0x80|0x2A while EN high:
//     - rd_data=0xAA, busy_flag=1, addr=0x2A.
//     - done_tick exactly 41 cycles after start.
//     - EN high exactly 12 cycles; RW high 2 cycles before EN and 2 after.
//  3 start, rs_sel=1; model drives 0x48 ('H'):
//     - rd_data=0x48, busy_flag/addr unchanged, lcd_rs=1 for whole transaction.
//  4 start pulsed every cycle during a transaction:
//     - exactly one done_tick per 41 cycles.
//     - re-issue on the done_tick cycle starts a new SETUP next cycle.
//  5 LCD_BUSY_POLL_EN; model returns BF=1 for 3 reads then 0x05:
//     - 4 EN pulses, one done_tick, poll_timeout=0, addr=0x05.
//  6 LCD_BUSY_POLL_EN; BF stuck at 1:
//     - 255 EN pulses then done_tick with poll_timeout=1.
//     - Next poll_start clears poll_timeout.

Source files
------------

// File: rtl/lcd_receive_if.sv
// Request/response and LCD pad signals of lcd_receive.
// poll_start/poll_timeout exist only when LCD_BUSY_POLL_EN is defined.
interface lcd_receive_if;
   logic       start;
   logic       rs_sel;
   logic [7:0] lcd_d_in;
   logic       bus_req;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic [7:0] rd_data;
   logic       busy_flag;
   logic [6:0] addr;
   logic       done_tick;
`ifdef LCD_BUSY_POLL_EN
   logic       poll_start;
   logic       poll_timeout;

   modport master (
      output start, rs_sel, poll_start, lcd_d_in,
      input  bus_req, lcd_rs, lcd_rw, lcd_en, rd_data, busy_flag, addr, done_tick, poll_timeout
   );
   modport slave (
      input  start, rs_sel, poll_start, lcd_d_in,
      output bus_req, lcd_rs, lcd_rw, lcd_en, rd_data, busy_flag, addr, done_tick, poll_timeout
   );
`else
   modport master (
      output start, rs_sel, lcd_d_in,
      input  bus_req, lcd_rs, lcd_rw, lcd_en, rd_data, busy_flag, addr, done_tick
   );
   modport slave (
      input  start, rs_sel, lcd_d_in,
      output bus_req, lcd_rs, lcd_rw, lcd_en, rd_data, busy_flag, addr, done_tick
   );
`endif
endinterface

// File: rtl/lcd_receive.sv
// HD44780 8-bit read-cycle engine: single RS=0/RS=1 reads on request.
// Optional busy-flag polling is built when LCD_BUSY_POLL_EN is defined.
module lcd_receive #(
   parameter int unsigned T_AS   = 2,
   parameter int unsigned T_PW   = 12,
   parameter int unsigned T_HOLD = 2,
   parameter int unsigned T_REC  = 24
`ifdef LCD_BUSY_POLL_EN
   ,
   parameter int unsigned T_TO   = 255
`endif
) (
   input logic         clk,
   input logic         rst,
   lcd_receive_if.slave bus
);

   localparam logic [7:0] AsLoad   = 8'(T_AS - 1);
   localparam logic [7:0] PwLoad   = 8'(T_PW - 1);
   localparam logic [7:0] HoldLoad = 8'(T_HOLD - 1);
   localparam logic [7:0] RecLoad  = 8'(T_REC - 1);
`ifdef LCD_BUSY_POLL_EN
   localparam logic [7:0] ToLimit  = 8'(T_TO);
`endif

   typedef enum logic [2:0] {StIdle, StSetup, StEnhi, StHold, StRecov} state_e;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       bus_req_q, bus_req_d;
   logic       rs_q, rs_d;
   logic       rw_q, rw_d;
   logic       en_q, en_d;
   logic       done_q, done_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       busy_q, busy_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] d_sync_q;
   logic       launch;
`ifdef LCD_BUSY_POLL_EN
   logic       poll_q, poll_d;
   logic [7:0] poll_cnt_q, poll_cnt_d;
   logic       timeout_q, timeout_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bus_req_d = bus_req_q;
      rs_d      = rs_q;
      rw_d      = rw_q;
      en_d      = en_q;
      done_d    = 1'b0;
      rd_data_d = rd_data_q;
      busy_d    = busy_q;
      addr_d    = addr_q;
      launch    = 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_d     = poll_q;
      poll_cnt_d = poll_cnt_q;
      timeout_d  = timeout_q;
`endif

      unique case (state_q)
         StIdle: begin
`ifdef LCD_BUSY_POLL_EN
            if (bus.poll_start) begin
               poll_d     = 1'b1;
               poll_cnt_d = 8'd0;
               timeout_d  = 1'b0;
               rs_d       = 1'b0;
               launch     = 1'b1;
            end else if (bus.start) begin
               poll_d    = 1'b0;
               timeout_d = 1'b0;
               rs_d      = bus.rs_sel;
               launch    = 1'b1;
            end
`else
            if (bus.start) begin
               rs_d   = bus.rs_sel;
               launch = 1'b1;
            end
`endif
         end
         StSetup: begin
            if (cnt_q == 8'd0) begin
               en_d    = 1'b1;
               cnt_d   = PwLoad;
               state_d = StEnhi;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StEnhi: begin
            if (cnt_q == 8'd0) begin
               // d_sync_q holds the bus as it was one cycle before EN falls.
               rd_data_d = d_sync_q;
               if (!rs_q) begin
                  busy_d = d_sync_q[7];
                  addr_d = d_sync_q[6:0];
               end
`ifdef LCD_BUSY_POLL_EN
               if (poll_q) poll_cnt_d = poll_cnt_q + 8'd1;
`endif
               en_d    = 1'b0;
               cnt_d   = HoldLoad;
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StHold: begin
            if (cnt_q == 8'd0) begin
               rw_d      = 1'b0;
               rs_d      = 1'b0;
               bus_req_d = 1'b0;
               cnt_d     = RecLoad;
               state_d   = StRecov;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StRecov: begin
            if (cnt_q == 8'd0) begin
`ifdef LCD_BUSY_POLL_EN
               if (poll_q && rd_data_q[7] && (poll_cnt_q != ToLimit)) begin
                  launch = 1'b1;
               end else begin
                  done_d    = 1'b1;
                  state_d   = StIdle;
                  timeout_d = poll_q & rd_data_q[7];
                  poll_d    = 1'b0;
               end
`else
               done_d  = 1'b1;
               state_d = StIdle;
`endif
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (launch) begin
         state_d   = StSetup;
         cnt_d     = AsLoad;
         bus_req_d = 1'b1;
         rw_d      = 1'b1;
         en_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         bus_req_q <= 1'b0;
         rs_q      <= 1'b0;
         rw_q      <= 1'b0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         rd_data_q <= 8'd0;
         busy_q    <= 1'b1;
         addr_q    <= 7'd0;
         d_sync_q  <= 8'd0;
`ifdef LCD_BUSY_POLL_EN
         poll_q     <= 1'b0;
         poll_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_req_q <= bus_req_d;
         rs_q      <= rs_d;
         rw_q      <= rw_d;
         en_q      <= en_d;
         done_q    <= done_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         addr_q    <= addr_d;
         d_sync_q  <= bus.lcd_d_in;
`ifdef LCD_BUSY_POLL_EN
         poll_q     <= poll_d;
         poll_cnt_q <= poll_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign bus.bus_req   = bus_req_q;
   assign bus.lcd_rs    = rs_q;
   assign bus.lcd_rw    = rw_q;
   assign bus.lcd_en    = en_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.busy_flag = busy_q;
   assign bus.addr      = addr_q;
   assign bus.done_tick = done_q;
`ifdef LCD_BUSY_POLL_EN
   assign bus.poll_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_lcd_receive.sv
// Directed bench for lcd_receive: table of single reads plus reset, back-to-back
// and (with LCD_BUSY_POLL_EN) busy-poll sequences.
module tb_lcd_receive;

   localparam int Lat = 1 + 2 + 12 + 2 + 24;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [7:0] model_resp = 8'h00;
   int tests = 0;
   int failed = 0;

   lcd_receive_if bus_if ();

   lcd_receive dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Panel model: drives its response only while EN is high.
   always_comb bus_if.lcd_d_in = bus_if.lcd_en ? model_resp : 8'h00;

   typedef struct {
      logic       rs;
      logic [7:0] resp;
      logic [7:0] exp_rd;
      logic       exp_bf;
      logic [6:0] exp_addr;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_txn(input logic rs, input logic [7:0] resp, output int lat,
                           output int en_cyc, output int setup, output int hold,
                           output int bad);
      bit seen_en;
      lat = -1; en_cyc = 0; setup = 0; hold = 0; bad = 0; seen_en = 0;
      model_resp = resp;
      bus_if.rs_sel = rs;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      bus_if.rs_sel = ~rs;
      for (int n = 1; n <= 200; n++) begin
         if (bus_if.done_tick) begin
            lat = n;
            break;
         end
         if (bus_if.lcd_en) begin
            en_cyc++;
            seen_en = 1;
            if (!bus_if.lcd_rw) bad++;
         end else if (bus_if.lcd_rw) begin
            if (seen_en) hold++;
            else setup++;
         end
         if (bus_if.lcd_rw && (bus_if.lcd_rs !== rs)) bad++;
         if (bus_if.bus_req !== bus_if.lcd_rw) bad++;
         tick();
      end
   endtask

`ifdef LCD_BUSY_POLL_EN
   task automatic poll_txn(input int n_busy, output int pulses, output int lat,
                           output logic to_at_start, output int bad);
      logic en_prev;
      pulses = 0; lat = -1; bad = 0; en_prev = 1'b0;
      model_resp = (n_busy > 0) ? 8'h91 : 8'h05;
      bus_if.poll_start = 1'b1;
      bus_if.start = 1'b1;
      bus_if.rs_sel = 1'b1;
      tick();
      bus_if.poll_start = 1'b0;
      bus_if.start = 1'b0;
      to_at_start = bus_if.poll_timeout;
      for (int n = 1; n <= 255 * 45; n++) begin
         if (bus_if.done_tick) begin
            lat = n;
            break;
         end
         if (bus_if.lcd_en && !en_prev) begin
            pulses++;
            model_resp = (pulses <= n_busy) ? 8'h91 : 8'h05;
         end
         if (bus_if.lcd_rw && bus_if.lcd_rs) bad++;
         en_prev = bus_if.lcd_en;
         tick();
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, en_cyc, setup, hold, bad, dones, last;
      bit chk_next;

      vecs[0] = '{rs: 1'b0, resp: 8'hAA, exp_rd: 8'hAA, exp_bf: 1'b1, exp_addr: 7'h2A};
      vecs[1] = '{rs: 1'b1, resp: 8'h48, exp_rd: 8'h48, exp_bf: 1'b1, exp_addr: 7'h2A};
      vecs[2] = '{rs: 1'b0, resp: 8'hFF, exp_rd: 8'hFF, exp_bf: 1'b1, exp_addr: 7'h7F};
      vecs[3] = '{rs: 1'b0, resp: 8'h15, exp_rd: 8'h15, exp_bf: 1'b0, exp_addr: 7'h15};
      vecs[4] = '{rs: 1'b1, resp: 8'hC3, exp_rd: 8'hC3, exp_bf: 1'b0, exp_addr: 7'h15};

      bus_if.start = 1'b0;
      bus_if.rs_sel = 1'b0;
`ifdef LCD_BUSY_POLL_EN
      bus_if.poll_start = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_bus_req", 32'(bus_if.bus_req), 0);
      chk("rst_lcd_rs", 32'(bus_if.lcd_rs), 0);
      chk("rst_lcd_rw", 32'(bus_if.lcd_rw), 0);
      chk("rst_lcd_en", 32'(bus_if.lcd_en), 0);
      chk("rst_rd_data", 32'(bus_if.rd_data), 0);
      chk("rst_busy_flag", 32'(bus_if.busy_flag), 1);
      chk("rst_addr", 32'(bus_if.addr), 0);
      chk("rst_done_tick", 32'(bus_if.done_tick), 0);
      rst = 1'b1;
      repeat (4) tick();

      for (int i = 0; i < 5; i++) begin
         read_txn(vecs[i].rs, vecs[i].resp, lat, en_cyc, setup, hold, bad);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(Lat));
         chk($sformatf("v%0d_en_cycles", i), 32'(en_cyc), 12);
         chk($sformatf("v%0d_rw_setup", i), 32'(setup), 2);
         chk($sformatf("v%0d_rw_hold", i), 32'(hold), 2);
         chk($sformatf("v%0d_bus_signals", i), 32'(bad), 0);
         chk($sformatf("v%0d_rd_data", i), 32'(bus_if.rd_data), 32'(vecs[i].exp_rd));
         chk($sformatf("v%0d_busy_flag", i), 32'(bus_if.busy_flag), 32'(vecs[i].exp_bf));
         chk($sformatf("v%0d_addr", i), 32'(bus_if.addr), 32'(vecs[i].exp_addr));
         tick();
         chk($sformatf("v%0d_done_one_cycle", i), 32'(bus_if.done_tick), 0);
      end

      // Reset while EN is high: strobes must drop without waiting for a clock.
      bus_if.rs_sel = 1'b0;
      model_resp = 8'hEE;
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      repeat (7) tick();
      chk("midrst_en_before", 32'(bus_if.lcd_en), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_en", 32'(bus_if.lcd_en), 0);
      chk("midrst_rw", 32'(bus_if.lcd_rw), 0);
      chk("midrst_bus_req", 32'(bus_if.bus_req), 0);
      repeat (2) tick();
      rst = 1'b1;
      dones = 0;
      for (int n = 0; n < 50; n++) begin
         if (bus_if.done_tick || bus_if.bus_req) dones++;
         tick();
      end
      chk("midrst_no_done", 32'(dones), 0);
      chk("midrst_busy_flag", 32'(bus_if.busy_flag), 1);
      chk("midrst_rd_data", 32'(bus_if.rd_data), 0);

      // start held high: re-issued on each done_tick, ignored elsewhere.
      bus_if.rs_sel = 1'b0;
      model_resp = 8'h33;
      bus_if.start = 1'b1;
      tick();
      dones = 0; last = 0; chk_next = 0;
      for (int n = 1; n <= 130; n++) begin
         if (chk_next) begin
            chk("b2b_reissue_bus_req", 32'(bus_if.bus_req), 1);
            chk_next = 0;
         end
         if (bus_if.done_tick) begin
            dones++;
            chk("b2b_spacing", 32'(n - last), 32'(Lat));
            last = n;
            chk_next = 1;
         end
         tick();
      end
      chk("b2b_done_count", 32'(dones), 3);
      bus_if.start = 1'b0;
      dones = 0;
      for (int n = 0; n < 60; n++) begin
         if (bus_if.done_tick) dones++;
         tick();
      end
      chk("b2b_drain_done", 32'(dones), 1);
      chk("b2b_rd_data", 32'(bus_if.rd_data), 32'h33);
      chk("b2b_addr", 32'(bus_if.addr), 32'h33);

`ifdef LCD_BUSY_POLL_EN
      begin
         int pulses;
         logic to_s;
         poll_txn(3, pulses, lat, to_s, bad);
         chk("poll_pulses", 32'(pulses), 4);
         chk("poll_done_seen", 32'(lat > 0), 1);
         chk("poll_rs_low", 32'(bad), 0);
         chk("poll_timeout", 32'(bus_if.poll_timeout), 0);
         chk("poll_addr", 32'(bus_if.addr), 32'h05);
         chk("poll_busy_flag", 32'(bus_if.busy_flag), 0);
         tick();
         chk("poll_single_done", 32'(bus_if.done_tick), 0);

         poll_txn(100000, pulses, lat, to_s, bad);
         chk("to_pulses", 32'(pulses), 255);
         chk("to_done_seen", 32'(lat > 0), 1);
         chk("to_timeout", 32'(bus_if.poll_timeout), 1);
         chk("to_busy_flag", 32'(bus_if.busy_flag), 1);
         tick();

         poll_txn(0, pulses, lat, to_s, bad);
         chk("to_clear_on_start", 32'(to_s), 0);
         chk("to_clear_pulses", 32'(pulses), 1);
         chk("to_clear_timeout", 32'(bus_if.poll_timeout), 0);
         chk("to_clear_addr", 32'(bus_if.addr), 32'h05);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
